serial_word_feeder: RTL and testbench

- Parallel-to-serial stage that sits directly upstream of the team's serial Mealy sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clk on the detector's w input.
- A one-entry holding buffer lets back-to-back words stream with no idle gap.
- Drives IDLE_BIT when it has no data, so the detector sees a defined level.

---
 rtl/serial_word_feeder.sv | 120 ++++++++++++
 tb/tb_serial_word_feeder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_feeder.sv
// serial_word_feeder: parallel-to-serial front end for the sequence detector.
// One-entry holding buffer keeps back-to-back words streaming without gaps.
module serial_word_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             w,
  output logic             bit_valid,
  output logic             word_done,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last;
  logic             load;

  assign in_ready = reset & ~hold_full;
  assign accept   = in_valid & in_ready;
  assign last     = (state == SHIFT) && (cnt == LAST);
  // HOLD feeds SR when idle or on the final bit edge of the current word
  assign load     = hold_full & ((state == IDLE) | last);
  assign busy     = (state == SHIFT) | hold_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (hold_full) state_nx = SHIFT;
      end
      SHIFT: begin
        if (last && !hold_full) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    w         = IDLE_BIT;
    bit_valid = 1'b0;
    word_done = 1'b0;
    unique case (state)
      IDLE: begin
        w = IDLE_BIT;
      end
      SHIFT: begin
        w         = MSB_FIRST ? sr[WIDTH-1] : sr[0];
        bit_valid = 1'b1;
        word_done = (cnt == LAST);
      end
      default: begin
        w = IDLE_BIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= hold;
      cnt <= '0;
    end else if (state == SHIFT) begin
      sr  <= MSB_FIRST ? {sr[WIDTH-2:0], 1'b0}
                       : {1'b0, sr[WIDTH-1:1]};
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold      <= in_data;
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      words_sent <= '0;
    end else if (last) begin
      words_sent <= words_sent + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// tb_serial_word_feeder: random + directed stimulus on two feeder variants
// checked every cycle against a word-queue model of the bit stream.
module tb_serial_word_feeder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  bit         run = 1'b0;

  always #5 clk = ~clk;

  logic        rdy0, w0, bv0, wd0, busy0;
  logic [15:0] ws0;
  logic        rdy1, w1, bv1, wd1, busy1;
  logic [3:0]  ws1;

  serial_word_feeder #(
    .WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1), .CNT_W(16)
  ) u0 (
    .clk(clk), .reset(rst_n),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy0), .w(w0), .bit_valid(bv0),
    .word_done(wd0), .busy(busy0), .words_sent(ws0)
  );

  serial_word_feeder #(
    .WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0), .CNT_W(4)
  ) u1 (
    .clk(clk), .reset(rst_n),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy1), .w(w1), .bit_valid(bv1),
    .word_done(wd1), .busy(busy1), .words_sent(ws1)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: pending words waiting, current word and bit position
  logic [7:0] pend_q[$];
  logic [7:0] cur = 8'h00;
  int         pos = 0;
  bit         m_act = 1'b0;
  int         sent = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q.delete();
      m_act = 1'b0;
      pos = 0;
      cur = 8'h00;
      sent = 0;
    end else begin
      bit acc;
      acc = in_valid && (pend_q.size() == 0);
      if (m_act) begin
        if (pos == 7) begin
          sent++;
          if (pend_q.size() > 0) begin
            cur = pend_q.pop_front();
            pos = 0;
          end else begin
            m_act = 1'b0;
          end
        end else begin
          pos++;
        end
      end else if (pend_q.size() > 0) begin
        cur = pend_q.pop_front();
        pos = 0;
        m_act = 1'b1;
      end
      if (acc) pend_q.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    if (run) begin
      logic ew0, ew1, erdy, ebusy, edone;
      ew0   = m_act ? cur[7-pos] : 1'b1;
      ew1   = m_act ? cur[pos] : 1'b0;
      erdy  = rst_n && (pend_q.size() == 0);
      ebusy = m_act || (pend_q.size() > 0);
      edone = m_act && (pos == 7);
      chk("w0", 32'(w0), 32'(ew0));
      chk("w1", 32'(w1), 32'(ew1));
      chk("bit_valid0", 32'(bv0), 32'(m_act));
      chk("bit_valid1", 32'(bv1), 32'(m_act));
      chk("word_done0", 32'(wd0), 32'(edone));
      chk("word_done1", 32'(wd1), 32'(edone));
      chk("in_ready0", 32'(rdy0), 32'(erdy));
      chk("in_ready1", 32'(rdy1), 32'(erdy));
      chk("busy0", 32'(busy0), 32'(ebusy));
      chk("busy1", 32'(busy1), 32'(ebusy));
      chk("words_sent0", 32'(ws0), sent % 65536);
      chk("words_sent1", 32'(ws1), sent % 16);
    end
  end

  logic c0[$];
  logic c1[$];
  logic cd[$];
  int   cc[$];
  int   cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (bv0) begin
      c0.push_back(w0);
      cd.push_back(wd0);
      cc.push_back(cyc);
    end
    if (bv1) c1.push_back(w1);
  end

  function automatic logic [31:0] pack(input logic q[$]);
    logic [31:0] r;
    r = '0;
    foreach (q[i]) r = {r[30:0], q[i]};
    return r;
  endfunction

  task automatic clr();
    c0.delete();
    c1.delete();
    cd.delete();
    cc.delete();
  endtask

  task automatic send(input logic [7:0] d);
    int n;
    in_data = d;
    in_valid = 1'b1;
    n = 0;
    while (!rdy0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_ready", 32'(rdy0), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 32'(busy0), 32'd0);
  endtask

  task automatic pulse_reset(input int len);
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (len) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    run = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_w", 32'(w0), 32'd1);
    chk("rst_bv", 32'(bv0), 32'd0);
    chk("rst_rdy", 32'(rdy0), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_ws", 32'(ws0), 32'd0);

    clr();
    send(8'h33);
    wait_idle();
    chk("bits_33", pack(c0), 32'h33);
    chk("len_33", c0.size(), 32'd8);
    chk("done_33", pack(cd), 32'h01);
    chk("after_w", 32'(w0), 32'd1);
    chk("after_bv", 32'(bv0), 32'd0);
    chk("ws_33", 32'(ws0), 32'd1);

    clr();
    send(8'hA5);
    send(8'h0F);
    wait_idle();
    chk("stream_bits", pack(c0), 32'hA50F);
    chk("stream_len", c0.size(), 32'd16);
    if (cc.size() == 16) chk("stream_gap", cc[15] - cc[0], 32'd15);
    chk("ws_stream", 32'(ws0), 32'd3);

    clr();
    send(8'h01);
    wait_idle();
    chk("lsb_01", pack(c1), 32'h80);
    chk("msb_01", pack(c0), 32'h01);
    chk("ws1_01", 32'(ws1), 32'd4);

    clr();
    send(8'hF0);
    send(8'h55);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_bits", pack(c0), 32'h7);
    chk("mid_len", c0.size(), 32'd3);
    chk("mid_w0", 32'(w0), 32'd1);
    chk("mid_w1", 32'(w1), 32'd0);
    chk("mid_rdy", 32'(rdy0), 32'd0);
    chk("mid_done", 32'(wd0), 32'd0);
    chk("mid_ws", 32'(ws0), 32'd0);
    chk("mid_busy", 32'(busy0), 32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_busy", 32'(busy0), 32'd0);
    clr();
    send(8'hC3);
    wait_idle();
    chk("bits_c3", pack(c0), 32'hC3);
    chk("len_c3", c0.size(), 32'd8);
    chk("ws_c3", 32'(ws0), 32'd1);

    pulse_reset(1);
    for (int i = 1; i <= 17; i++) begin
      send(8'(i * 7));
      wait_idle();
      if (i == 15) chk("cnt4_15", 32'(ws1), 32'd15);
      if (i == 16) chk("cnt4_16", 32'(ws1), 32'd0);
      if (i == 17) chk("cnt4_17", 32'(ws1), 32'd1);
    end
    chk("cnt16_17", 32'(ws0), 32'd17);

    repeat (300) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 39) == 0) pulse_reset(1);
      if (!rdy0 && $urandom_range(0, 3) == 0) begin
        in_data = 8'($urandom);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
      end
      send(8'($urandom));
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

endmodule
